// File: rtl/dmem_port_arbiter_if.sv
// dmem_port_arbiter_if
//  Bus bundle for the two-requester data-memory arbiter: both requester
//  handshakes, the DataMemory side, and the busy/grant status.
//  slave  : the arbiter's view (requests and memory read data in).
//  master : the environment's view (requesters plus DataMemory).
interface dmem_port_arbiter_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);
  logic              req0;
  logic              req1;
  logic              we0;
  logic              we1;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata0;
  logic [DATA_W-1:0] wdata1;
  logic              ack0;
  logic              ack1;
  logic [DATA_W-1:0] rdata0;
  logic [DATA_W-1:0] rdata1;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_re;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;
  logic              grant_id;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
    output ack0, ack1, rdata0, rdata1, mem_addr, mem_wdata, mem_re, mem_we,
           busy, grant_id
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
    input  ack0, ack1, rdata0, rdata1, mem_addr, mem_wdata, mem_re, mem_we,
           busy, grant_id
  );
endinterface

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter
//  Round-robin sharing of the single data-memory port between the CPU
//  load/store path (port 0) and the DMA/debug loader (port 1).
//  Each access: IDLE (grant) -> ACCESS (MEM_LAT cycles of mem_re/mem_we)
//  -> RESP (one-cycle ack) -> IDLE.  Requests are not sampled in RESP.
//  Optional feature macro: DMEM_ARB_PERF_EN adds grant and conflict counters.
module dmem_port_arbiter #(
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 64,
  parameter int MEM_LAT = 1     // 1..15
) (
  input  logic        clk_i,
  input  logic        rst_i,
  dmem_port_arbiter_if.slave bus
`ifdef DMEM_ARB_PERF_EN
  ,
  output logic [31:0] gnt_cnt0_o,
  output logic [31:0] gnt_cnt1_o,
  output logic [31:0] conflict_cnt_o
`endif
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              rr_q, rr_d;
  logic              gnt_q, gnt_d;
  logic              busy_q, busy_d;
  logic              ack0_q, ack0_d;
  logic              ack1_q, ack1_d;
  logic              mem_re_q, mem_re_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] maddr_q, maddr_d;
  logic [DATA_W-1:0] mwdata_q, mwdata_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;
  logic              sel_s;

  // Next-state and next-output logic for the access sequencer.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rr_d     = rr_q;
    gnt_d    = gnt_q;
    ack0_d   = 1'b0;
    ack1_d   = 1'b0;
    mem_re_d = mem_re_q;
    mem_we_d = mem_we_q;
    maddr_d  = maddr_q;
    mwdata_d = mwdata_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    sel_s    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          // Contention goes to the round-robin pointer; otherwise to the lone requester.
          if (bus.req0 && bus.req1) begin
            sel_s = rr_q;
          end else begin
            sel_s = bus.req1;
          end
          gnt_d = sel_s;
          if (sel_s) begin
            maddr_d  = bus.addr1;
            mwdata_d = bus.wdata1;
            mem_re_d = ~bus.we1;
            mem_we_d = bus.we1;
          end else begin
            maddr_d  = bus.addr0;
            mwdata_d = bus.wdata0;
            mem_re_d = ~bus.we0;
            mem_we_d = bus.we0;
          end
          cnt_d   = LAT_M1;
          state_d = ACCESS;
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
        if (cnt_q == 4'd0) begin
          state_d  = RESP;
          mem_re_d = 1'b0;
          mem_we_d = 1'b0;
          if (gnt_q) begin
            ack1_d = 1'b1;
          end else begin
            ack0_d = 1'b1;
          end
          // Read data is taken in the final ACCESS cycle; writes leave rdata alone.
          if (mem_re_q && gnt_q) begin
            rdata1_d = bus.mem_rdata;
          end else if (mem_re_q) begin
            rdata0_d = bus.mem_rdata;
          end else begin
            rdata0_d = rdata0_q;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        rr_d    = ~gnt_q;
        state_d = IDLE;
      end
      default: begin
        state_d  = IDLE;
        mem_re_d = 1'b0;
        mem_we_d = 1'b0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset aborts any access immediately.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      rr_q     <= 1'b0;
      gnt_q    <= 1'b0;
      busy_q   <= 1'b0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      mem_re_q <= 1'b0;
      mem_we_q <= 1'b0;
      maddr_q  <= '0;
      mwdata_q <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rr_q     <= rr_d;
      gnt_q    <= gnt_d;
      busy_q   <= busy_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
      mem_re_q <= mem_re_d;
      mem_we_q <= mem_we_d;
      maddr_q  <= maddr_d;
      mwdata_q <= mwdata_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  assign bus.ack0      = ack0_q;
  assign bus.ack1      = ack1_q;
  assign bus.rdata0    = rdata0_q;
  assign bus.rdata1    = rdata1_q;
  assign bus.mem_addr  = maddr_q;
  assign bus.mem_wdata = mwdata_q;
  assign bus.mem_re    = mem_re_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.busy      = busy_q;
  assign bus.grant_id  = gnt_q;

`ifdef DMEM_ARB_PERF_EN
  logic [31:0] gnt_cnt0_q;
  logic [31:0] gnt_cnt1_q;
  logic [31:0] conflict_cnt_q;

  // Per-port grant counts (bumped in RESP) and IDLE-cycle contention count; all wrap.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      gnt_cnt0_q     <= 32'd0;
      gnt_cnt1_q     <= 32'd0;
      conflict_cnt_q <= 32'd0;
    end else begin
      if (state_q == RESP && !gnt_q) begin
        gnt_cnt0_q <= gnt_cnt0_q + 32'd1;
      end
      if (state_q == RESP && gnt_q) begin
        gnt_cnt1_q <= gnt_cnt1_q + 32'd1;
      end
      if (state_q == IDLE && bus.req0 && bus.req1) begin
        conflict_cnt_q <= conflict_cnt_q + 32'd1;
      end
    end
  end

  assign gnt_cnt0_o     = gnt_cnt0_q;
  assign gnt_cnt1_o     = gnt_cnt1_q;
  assign conflict_cnt_o = conflict_cnt_q;
`endif

endmodule
